// File: rtl/y86_regfile.sv
// Y86-64 program register file: 15 x WIDTH registers, two combinational read ports, two clocked write ports.
// Optional write-through read ports when REGFILE_BYPASS_EN is defined.
module y86_regfile #(
    parameter int unsigned      WIDTH    = 64,
    parameter logic [WIDTH-1:0] SP_RESET = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [3:0]       srcA,
    input  logic [3:0]       srcB,
    output logic [WIDTH-1:0] valA,
    output logic [WIDTH-1:0] valB,
    input  logic [3:0]       dstE,
    input  logic [WIDTH-1:0] valE,
    input  logic [3:0]       dstM,
    input  logic [WIDTH-1:0] valM,
    output logic [WIDTH-1:0] rsp_dbg
);

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RSP   = 4'h4;

    logic [WIDTH-1:0] r_regs [15];
    logic [WIDTH-1:0] w_rdA;
    logic [WIDTH-1:0] w_rdB;

    // Per-register compare instead of indexing by dst, so ID 0xF never selects a slot.
    always_ff @(posedge clock) begin
        for (int unsigned i = 0; i < 15; i++) begin
            if (reset) begin
                r_regs[i] <= (4'(i) == RSP) ? SP_RESET : '0;
            end else if (enable) begin
                if (dstM == 4'(i)) begin
                    r_regs[i] <= valM;
                end else if (dstE == 4'(i)) begin
                    r_regs[i] <= valE;
                end
            end
        end
    end

    always_comb begin
        w_rdA = '0;
        w_rdB = '0;
        for (int unsigned i = 0; i < 15; i++) begin
            if (srcA == 4'(i)) w_rdA = r_regs[i];
            if (srcB == 4'(i)) w_rdB = r_regs[i];
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic w_wrE;
    logic w_wrM;

    assign w_wrE = enable && !reset && (dstE != RNONE);
    assign w_wrM = enable && !reset && (dstM != RNONE);

    always_comb begin
        valA = w_rdA;
        valB = w_rdB;
        if (w_wrM && dstM == srcA)      valA = valM;
        else if (w_wrE && dstE == srcA) valA = valE;
        if (w_wrM && dstM == srcB)      valB = valM;
        else if (w_wrE && dstE == srcB) valB = valE;
    end
`else
    assign valA = w_rdA;
    assign valB = w_rdB;
`endif

    assign rsp_dbg = r_regs[RSP];

endmodule

// File: tb/tb_y86_regfile.sv
// Directed self-checking bench for y86_regfile with SP_RESET = 64'h100.
module tb_y86_regfile;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [3:0]  srcA, srcB, dstE, dstM;
    logic [63:0] valA, valB, valE, valM, rsp_dbg;

    logic [63:0] r_exp [15];
    int          n_tests = 0;
    int          n_fail  = 0;

    y86_regfile #(.WIDTH(64), .SP_RESET(64'h100)) dut (
        .clock   (clock),
        .reset   (reset),
        .enable  (enable),
        .srcA    (srcA),
        .srcB    (srcB),
        .valA    (valA),
        .valB    (valB),
        .dstE    (dstE),
        .valE    (valE),
        .dstM    (dstM),
        .valM    (valM),
        .rsp_dbg (rsp_dbg)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic sweep(input string tag);
        for (int i = 0; i < 15; i++) begin
            srcA = 4'(i);
            srcB = 4'(14 - i);
            #1;
            check($sformatf("%s_A%0d", tag, i), valA, r_exp[i]);
            check($sformatf("%s_B%0d", tag, 14 - i), valB, r_exp[14 - i]);
        end
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b1;
        srcA   = 4'h0;
        srcB   = 4'h0;
        dstE   = 4'hF;
        dstM   = 4'hF;
        valE   = '0;
        valM   = '0;
        for (int i = 0; i < 15; i++) r_exp[i] = '0;
        r_exp[4] = 64'h100;

        // 1: reset values
        tick;
        reset = 1'b0;
        srcA = 4'h4;
        #1;
        check("rst_rsp_valA", valA, 64'h100);
        check("rst_rsp_dbg", rsp_dbg, 64'h100);
        sweep("rst");
        srcA = 4'hF;
        #1;
        check("rst_rnone", valA, 64'h0);

        // 2: single E write
        dstE = 4'h2; valE = 64'hDEAD;
        tick;
        dstE = 4'hF;
        r_exp[2] = 64'hDEAD;
        srcA = 4'h2;
        #1;
        check("wrE_reg2", valA, 64'hDEAD);
        sweep("wrE");

        // 3: same-destination collision, M wins
        dstE = 4'h3; valE = 64'h11;
        dstM = 4'h3; valM = 64'h22;
        tick;
        dstE = 4'hF; dstM = 4'hF;
        r_exp[3] = 64'h22;
        srcB = 4'h3;
        #1;
        check("coll_reg3", valB, 64'h22);

        // 4: stall blocks write
        enable = 1'b0;
        dstE = 4'h5; valE = 64'h55;
        tick;
        dstE = 4'hF;
        enable = 1'b1;
        srcA = 4'h5;
        #1;
        check("stall_reg5", valA, 64'h0);

        // 4b: reset overrides a write to %rsp
        reset = 1'b1;
        dstM = 4'h4; valM = 64'hBAD;
        dstE = 4'h2; valE = 64'h1234;
        tick;
        reset = 1'b0;
        dstM = 4'hF; dstE = 4'hF;
        for (int i = 0; i < 15; i++) r_exp[i] = '0;
        r_exp[4] = 64'h100;
        check("rst_wr_dbg", rsp_dbg, 64'h100);
        sweep("rstwr");

        // 5: RNONE reads and writes
        srcA = 4'hF; srcB = 4'hF;
        valE = '1; valM = '1;
        tick;
        check("rnone_A", valA, 64'h0);
        check("rnone_B", valB, 64'h0);
        sweep("rnone");

        // 6: same-cycle read of a register being written
        dstE = 4'h7; valE = 64'h70;
        tick;
        dstE = 4'hF;
        r_exp[7] = 64'h70;
        dstM = 4'h7; valM = 64'h77;
        srcA = 4'h7; srcB = 4'h7;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("byp_pre_A", valA, 64'h77);
        check("byp_pre_B", valB, 64'h77);
`else
        check("byp_pre_A", valA, 64'h70);
        check("byp_pre_B", valB, 64'h70);
`endif
        tick;
        dstM = 4'hF;
        r_exp[7] = 64'h77;
        check("byp_post_A", valA, 64'h77);

        // rsp_dbg is never bypassed
        dstM = 4'h4; valM = 64'h444;
        #1;
        check("dbg_pre", rsp_dbg, 64'h100);
        tick;
        dstM = 4'hF;
        r_exp[4] = 64'h444;
        check("dbg_post", rsp_dbg, 64'h444);
        sweep("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
